wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline; the writer end of the register-file write port.
- Latches MEM-stage results into a MEM/WB pipeline register and selects the write-back value: ALU result, extracted load data, or link address.
- Drives the register file's regWrite/WriteReg/WriteData inputs and exports a forwarding copy for the ID/EX bypass logic.
- Keeps a retired-instruction counter for debug and performance checks.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register-address width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_write  in  1  instruction writes a register.
- mem_mem_to_reg  in  1  write-back value comes from load data.
- mem_link  in  1  write-back value is mem_pc_plus8 (jal/jalr).
- mem_load_size  in  2  00 word, 01 byte, 10 half, 11 reserved.
- mem_load_signed  in  1  1 = sign-extend a byte/half load, 0 = zero-extend.
- mem_dest  in  ADDR_W  destination register.
- mem_alu_result  in  DATA_W  ALU result; bits [1:0] are the load byte offset.
- mem_load_data  in  DATA_W  raw data-memory word.
- mem_pc_plus8  in  DATA_W  link address.
- wb_stall  in  1  hold the stage.
- wb_flush  in  1  kill the stage contents.
- reg_write  out  1  register-file write enable.
- write_reg  out  ADDR_W  register-file write address.
- write_data  out  DATA_W  register-file write data.
- fwd_valid  out  1  write_reg/write_data are a valid bypass source.
- retired_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - Pipeline valid bit cleared; all latched fields cleared to 0; retired_count cleared to 0.
  - Outputs: reg_write=0, write_reg=0, write_data=0, fwd_valid=0, retired_count=0.
  - Reset asserted mid-operation discards the in-flight instruction; no write is issued.
- Pipeline register update, each posedge (priority order):
  - wb_flush=1 clears valid; the other fields don't care. Flush wins over stall.
  - Else wb_stall=1 holds every field.
  - Else all mem_* inputs are captured and valid is set to mem_valid.
- Latency: an instruction presented at MEM in cycle N drives the write port during cycle N+1. The register file commits it at the edge ending N+1.
- Write-back select, combinational from the latched fields (priority link > mem_to_reg > ALU):
  - link: write_data = pc_plus8.
  - mem_to_reg: write_data = extracted load.
  - otherwise: write_data = alu_result.
- Load extraction (off = latched alu_result[1:0]):
  - word (00, and reserved 11): whole word.
  - byte (01): byte lane off.
  - half (10): lane off[1]; off[0] is ignored (misalignment is trapped upstream).
  - Byte/half results are sign- or zero-extended to DATA_W per load_signed.
- Write gating:
  - reg_write = valid & latched reg_write & (dest != 0) & !wb_stall.
  - r0 is never written.
  - A stalled instruction writes exactly once, in its final non-stalled cycle.
- Address/data outputs:
  - write_reg = latched dest.
  - write_data is driven even when reg_write=0.
- Forwarding:
  - fwd_valid = valid & latched reg_write & (dest != 0). It is not gated by stall.
  - Register-file reads are combinational and the write lands at the clock edge, so an ID read of write_reg in the same cycle returns the old value. Consumers must use the fwd_* path.
- Retired counter:
  - Increments by 1 on each posedge where valid=1 and wb_stall=0, i.e. the instruction leaves the stage. Instructions with no register write also count.
  - Wraps from 2^CNT_W-1 to 0.
  - A flush does not count the killed instruction: flush takes precedence when flush and retire coincide.
- No X may propagate to the outputs from unused fields while valid=0.

Decomposition:
- Shared package mips_pkg:
  - load-size encodings LD_WORD=2'b00, LD_BYTE=2'b01, LD_HALF=2'b10.
  - REG_ZERO=5'd0.
  - DATA_W/ADDR_W defaults.
- Sub-module load_extract: combinational; inputs word, offset, size, signed; output DATA_W. It is reused by any later load-alignment logic.

Test Plan:
- Reset mid-stream: valid ALU write in flight, rst_n low → reg_write=0, retired_count=0 immediately (async); no write after release.
- ALU write: dest=5, alu=0x12345678, reg_write=1 → next cycle reg_write=1, write_reg=5, write_data=0x12345678, fwd_valid=1; retired_count 0→1.
- Byte load:
  - load_data=0x80FF7F01, offset 2, signed → write_data=0xFFFFFFFF.
  - offset 3, unsigned → 0x00000080.
  - half, offset 2, signed → 0xFFFF80FF.
- r0 suppression and link: dest=0 → reg_write=0, fwd_valid=0, retired_count still +1. link=1 with pc_plus8=0x00400010, dest=31 → write_data=0x00400010.
- Stall then flush: stall 3 cycles with a valid write held → reg_write=0 during the stall and 1 only in the release cycle; count +1 total. Then flush and stall together → valid cleared, no write, no count.
- Counter wrap: force retired_count to 0xFFFFFFFF, retire one instruction → 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: load-size encodings, the hard-wired
// zero register and default datapath widths.
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  // Load-size encodings carried down the pipeline with each load.
  // 2'b11 is reserved and is treated as a whole-word load.
  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_BYTE = 2'b01;
  localparam logic [1:0] LD_HALF = 2'b10;

  // Register r0 reads as zero and must never be written.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_extract.sv
// Load alignment: picks the addressed byte or halfword out of a raw memory word
// and sign- or zero-extends it. Purely combinational.
module load_extract
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the low word into its four byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word[8*gi +: 8];
  end

  assign byte_sel = lane[offset];
  // Halfword lane is chosen by offset[1] alone; a misaligned offset[0] never
  // reaches this point because the address is trapped upstream.
  assign half_sel = offset[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  // Select by size and extend the narrow results to the full datapath width.
  always_comb begin
    data = word;
    case (size)
      LD_BYTE: data = {{(DATA_W-8){is_signed & byte_sel[7]}}, byte_sel};
      LD_HALF: data = {{(DATA_W-16){is_signed & half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back value select,
// register-file write port, forwarding copy and retired-instruction counter.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W_DEFAULT,
  parameter int ADDR_W = mips_pkg::ADDR_W_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_link,
  input  logic [1:0]        mem_load_size,
  input  logic              mem_load_signed,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus8,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retired_count
);

  logic              valid_reg;
  logic              reg_write_reg;
  logic              mem_to_reg_reg;
  logic              link_reg;
  logic [1:0]        load_size_reg;
  logic              load_signed_reg;
  logic [ADDR_W-1:0] dest_reg;
  logic [DATA_W-1:0] alu_result_reg;
  logic [DATA_W-1:0] load_data_reg;
  logic [DATA_W-1:0] pc_plus8_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] load_value;
  logic              writes_reg;

  // MEM/WB register: flush kills the slot, stall holds it, otherwise capture.
  // All fields reset to 0 so nothing undefined reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg       <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
      link_reg        <= 1'b0;
      load_size_reg   <= LD_WORD;
      load_signed_reg <= 1'b0;
      dest_reg        <= '0;
      alu_result_reg  <= '0;
      load_data_reg   <= '0;
      pc_plus8_reg    <= '0;
    end else if (wb_flush) begin
      valid_reg <= 1'b0;
    end else if (!wb_stall) begin
      valid_reg       <= mem_valid;
      reg_write_reg   <= mem_reg_write;
      mem_to_reg_reg  <= mem_mem_to_reg;
      link_reg        <= mem_link;
      load_size_reg   <= mem_load_size;
      load_signed_reg <= mem_load_signed;
      dest_reg        <= mem_dest;
      alu_result_reg  <= mem_alu_result;
      load_data_reg   <= mem_load_data;
      pc_plus8_reg    <= mem_pc_plus8;
    end
  end

  // Count an instruction when it leaves the stage; a flushed one never does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (valid_reg && !wb_stall && !wb_flush) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .word     (load_data_reg),
    .offset   (alu_result_reg[1:0]),
    .size     (load_size_reg),
    .is_signed(load_signed_reg),
    .data     (load_value)
  );

  // Write-back value: link beats load data, which beats the ALU result.
  always_comb begin
    write_data = alu_result_reg;
    if (link_reg) begin
      write_data = pc_plus8_reg;
    end else if (mem_to_reg_reg) begin
      write_data = load_value;
    end
  end

  // A live write to anything but r0; the bypass sees it even while stalled,
  // but the register file only takes it in the cycle the stall releases.
  assign writes_reg    = valid_reg & reg_write_reg & (dest_reg != ADDR_W'(REG_ZERO));
  assign fwd_valid     = writes_reg;
  assign reg_write     = writes_reg & ~wb_stall;
  assign write_reg     = dest_reg;
  assign retired_count = count_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_reg_write, mem_mem_to_reg, mem_link;
  logic [1:0]  mem_load_size;
  logic        mem_load_signed;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus8;
  logic        wb_stall, wb_flush;

  logic        reg_write, fwd_valid, reg_write2, fwd_valid2;
  logic [4:0]  write_reg, write_reg2;
  logic [31:0] write_data, write_data2;
  logic [31:0] retired_count;
  logic [3:0]  retired_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link),
    .mem_load_size(mem_load_size), .mem_load_signed(mem_load_signed),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc_plus8(mem_pc_plus8),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .fwd_valid(fwd_valid), .retired_count(retired_count)
  );

  // Narrow-counter instance so wrap-around happens within a short run.
  wb_stage #(.CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link),
    .mem_load_size(mem_load_size), .mem_load_signed(mem_load_signed),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc_plus8(mem_pc_plus8),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .reg_write(reg_write2), .write_reg(write_reg2), .write_data(write_data2),
    .fwd_valid(fwd_valid2), .retired_count(retired_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mtr;
    logic        link;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc8;
  } slot_t;

  slot_t       m;
  logic [31:0] m_cnt;

  // Architectural value an instruction writes back.
  function automatic logic [31:0] wb_value(input slot_t s);
    logic [31:0] v;
    int unsigned off;
    off = s.alu % 4;
    if (s.link) return s.pc8;
    if (!s.mtr) return s.alu;
    if (s.size == 2'd1) begin
      v = (s.ld >> (8 * off)) & 32'hFF;
      if (s.sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (s.size == 2'd2) begin
      v = (s.ld >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
      if (s.sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return s.ld;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     <= '0;
      m_cnt <= 32'd0;
    end else begin
      if (wb_flush) m.valid <= 1'b0;
      else if (!wb_stall)
        m <= '{mem_valid, mem_reg_write, mem_mem_to_reg, mem_link, mem_load_size,
               mem_load_signed, mem_dest, mem_alu_result, mem_load_data, mem_pc_plus8};
      if (m.valid && !wb_stall && !wb_flush) m_cnt <= m_cnt + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic live;
    live = m.valid && m.rw && (m.dest != 5'd0);
    chk("reg_write", {31'd0, reg_write}, {31'd0, live && !wb_stall});
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, live});
    chk("write_reg", {27'd0, write_reg}, {27'd0, m.dest});
    chk("write_data", write_data, wb_value(m));
    chk("retired_count", retired_count, m_cnt);
    chk("retired_count_w4", {28'd0, retired_count2}, m_cnt % 16);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input string tag, input logic rw, input logic mtr, input logic lnk,
                       input logic [1:0] sz, input logic sg, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc8);
    mem_valid = 1'b1; mem_reg_write = rw; mem_mem_to_reg = mtr; mem_link = lnk;
    mem_load_size = sz; mem_load_signed = sg; mem_dest = d;
    mem_alu_result = alu; mem_load_data = ld; mem_pc_plus8 = pc8;
    $display("txn %s dest=%0d alu=%h ld=%h pc8=%h", tag, d, alu, ld, pc8);
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_valid = 0; mem_reg_write = 0; mem_mem_to_reg = 0; mem_link = 0;
    mem_load_size = 0; mem_load_signed = 0; mem_dest = 0;
    mem_alu_result = 0; mem_load_data = 0; mem_pc_plus8 = 0;
    wb_stall = 0; wb_flush = 0;

    @(negedge clk);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_count", retired_count, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    issue("alu", 1, 0, 0, 2'b00, 0, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
    @(negedge clk);
    chk("alu_rw", {31'd0, reg_write}, 32'd1);
    chk("alu_reg", {27'd0, write_reg}, 32'd5);
    chk("alu_data", write_data, 32'h1234_5678);
    chk("alu_fwd", {31'd0, fwd_valid}, 32'd1);
    chk("alu_cnt", retired_count, 32'd0);

    issue("lb_s_off2", 1, 1, 0, 2'b01, 1, 5'd8, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    @(negedge clk);
    chk("lb_s_off2", write_data, 32'hFFFF_FFFF);
    chk("lb_cnt", retired_count, 32'd1);
    issue("lbu_off3", 1, 1, 0, 2'b01, 0, 5'd8, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
    @(negedge clk);
    chk("lbu_off3", write_data, 32'h0000_0080);
    issue("lh_s_off2", 1, 1, 0, 2'b10, 1, 5'd8, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    @(negedge clk);
    chk("lh_s_off2", write_data, 32'hFFFF_80FF);

    issue("r0", 1, 0, 0, 2'b00, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    @(negedge clk);
    chk("r0_rw", {31'd0, reg_write}, 32'd0);
    chk("r0_fwd", {31'd0, fwd_valid}, 32'd0);
    chk("r0_cnt", retired_count, 32'd4);
    issue("link", 1, 1, 1, 2'b00, 0, 5'd31, 32'h1111_1111, 32'h2222_2222, 32'h0040_0010);
    @(negedge clk);
    chk("link_data", write_data, 32'h0040_0010);
    chk("link_cnt", retired_count, 32'd5);

    issue("stall", 1, 0, 0, 2'b00, 0, 5'd7, 32'h0000_00A5, 32'h0, 32'h0);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rw", {31'd0, reg_write}, 32'd0);
      chk("stall_fwd", {31'd0, fwd_valid}, 32'd1);
      @(posedge clk); #1;
    end
    wb_stall = 1'b0;
    @(negedge clk);
    chk("release_rw", {31'd0, reg_write}, 32'd1);
    chk("release_cnt", retired_count, 32'd6);

    issue("flush", 1, 0, 0, 2'b00, 0, 5'd9, 32'h0000_0099, 32'h0, 32'h0);
    wb_stall = 1'b1; wb_flush = 1'b1;
    @(negedge clk);
    chk("flush_cnt_before", retired_count, 32'd7);
    @(posedge clk); #1;
    wb_stall = 1'b0; wb_flush = 1'b0;
    @(negedge clk);
    chk("flush_fwd", {31'd0, fwd_valid}, 32'd0);
    chk("flush_rw", {31'd0, reg_write}, 32'd0);
    chk("flush_cnt", retired_count, 32'd7);

    for (int i = 0; i < 9; i++) issue("nowrite", 0, 0, 0, 2'b00, 0, 5'd3, i, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("cnt_16", retired_count, 32'd16);
    chk("wrap_w4", {28'd0, retired_count2}, 32'd0);

    issue("rst_mid", 1, 0, 0, 2'b00, 0, 5'd3, 32'h0000_0033, 32'h0, 32'h0);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rstmid_rw", {31'd0, reg_write}, 32'd0);
    chk("rstmid_cnt", retired_count, 32'd0);
    chk("rstmid_cnt_w4", {28'd0, retired_count2}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_after_rw", {31'd0, reg_write}, 32'd0);
    chk("rstmid_after_fwd", {31'd0, fwd_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      mem_valid       = ($urandom_range(0, 3) != 0);
      mem_reg_write   = $urandom_range(0, 1);
      mem_mem_to_reg  = $urandom_range(0, 1);
      mem_link        = ($urandom_range(0, 5) == 0);
      mem_load_size   = 2'($urandom_range(0, 3));
      mem_load_signed = $urandom_range(0, 1);
      mem_dest        = 5'($urandom_range(0, 31));
      mem_alu_result  = $urandom;
      mem_load_data   = $urandom;
      mem_pc_plus8    = $urandom;
      wb_stall        = ($urandom_range(0, 3) == 0);
      wb_flush        = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    wb_stall = 1'b0; wb_flush = 1'b0; mem_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
